// File: rtl/kgp_pkg.sv
// Shared definitions for the branch/PC stage: branch opcodes, ALU sign codes,
// FSM state encoding and the default reset PC.
package kgp_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_BR   = 3'b001,
    OP_BLTZ = 3'b010,
    OP_BZ   = 3'b011,
    OP_BNZ  = 3'b100,
    OP_BL   = 3'b101,
    OP_BCY  = 3'b110,
    OP_BNCY = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    SIGN_ZERO = 2'b00,
    SIGN_POS  = 2'b01,
    SIGN_NEG  = 2'b10,
    SIGN_ILL  = 2'b11
  } alu_sign_e;

  typedef enum logic [1:0] {
    RESET_IDLE = 2'b00,
    RUN        = 2'b01,
    HOLD       = 2'b10,
    FLUSH      = 2'b11
  } state_e;

  // Flag-dependent branches only; br, bl and seq do not count as conditional.
  function automatic logic is_cond_op(input logic [2:0] op);
    return (op == OP_BLTZ) || (op == OP_BZ) || (op == OP_BNZ) ||
           (op == OP_BCY)  || (op == OP_BNCY);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator from ALU sign and carry flag.
module branch_cond
  import kgp_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic [1:0] alu_sign,
  input  logic       carry,
  output logic       cond_taken
);

  always_comb begin
    cond_taken = 1'b0;
    case (br_op)
      OP_BR, OP_BL: cond_taken = 1'b1;
      OP_BLTZ:      cond_taken = (alu_sign == SIGN_NEG);
      OP_BZ:        cond_taken = (alu_sign == SIGN_ZERO);
      OP_BNZ:       cond_taken = (alu_sign != SIGN_ZERO);
      OP_BCY:       cond_taken = carry;
      OP_BNCY:      cond_taken = ~carry;
      default:      cond_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC sequencer and branch resolution with carry flag, link write and flush.
// Optional taken/not-taken statistics counters enabled by BRANCH_STATS_EN.
module branch_pc_unit
  import kgp_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     alu_result,
  input  logic [1:0]      alu_sign,
  input  logic            alu_cout,
  input  logic            flag_we,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_op,
  input  logic [PC_W-1:0] br_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic            flush,
  output logic            link_we,
  output logic [PC_W-1:0] link_data,
  output logic            carry
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     stat_taken,
  output logic [15:0]     stat_not_taken
`endif
);

  state_e          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target_aligned;
  logic            cond_taken;
  logic            accept;
  logic            br_take;
  logic            is_bl;
  logic            unused_alu_result;

  assign unused_alu_result = ^alu_result;

  assign pc_inc         = pc + PC_W'(4);
  assign target_aligned = {br_target[PC_W-1:2], 2'b00};
  assign accept         = br_valid & br_ready;
  assign br_take        = accept & cond_taken;
  assign is_bl          = accept & (br_op == OP_BL);

  // Registered carry feeds the evaluator, so a same-cycle flag_we sees the old value.
  branch_cond u_branch_cond (
    .br_op      (br_op),
    .alu_sign   (alu_sign),
    .carry      (carry),
    .cond_taken (cond_taken)
  );

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    br_ready = 1'b0;
    if_valid = 1'b1;
    case (state)
      RESET_IDLE: begin
        if_valid = 1'b0;
        state_nx = RUN;
      end
      RUN: begin
        br_ready = 1'b1;
        if (br_take) begin
          pc_nx    = target_aligned;
          state_nx = FLUSH;
        end else if (if_ready) begin
          pc_nx = pc_inc;
        end else begin
          state_nx = HOLD;
        end
      end
      HOLD, FLUSH: begin
        if (if_ready) begin
          pc_nx    = pc_inc;
          state_nx = RUN;
        end else begin
          state_nx = HOLD;
        end
      end
      default: state_nx = RESET_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_IDLE;
      pc        <= RESET_PC;
      carry     <= 1'b0;
      taken     <= 1'b0;
      flush     <= 1'b0;
      link_we   <= 1'b0;
      link_data <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      taken   <= br_take;
      flush   <= br_take;
      link_we <= is_bl;
      if (flag_we) carry <= alu_cout;
      if (is_bl) link_data <= pc_inc;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (accept && is_cond_op(br_op)) begin
      if (cond_taken) begin
        if (stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'd1;
      end else begin
        if (stat_not_taken != 16'hFFFF) stat_not_taken <= stat_not_taken + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: directed per-cycle vectors push
// expected outputs, a monitor pops and compares after each rising edge.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_result = '0;
  logic [1:0]  alu_sign = '0;
  logic        alu_cout = 1'b0;
  logic        flag_we = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [2:0]  br_op = '0;
  logic [31:0] br_target = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] pc;
  logic        taken;
  logic        flush;
  logic        link_we;
  logic [31:0] link_data;
  logic        carry;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken;
  logic [15:0] stat_not_taken;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic        lwe;
    logic [31:0] ld;
    logic        c;
    logic        br;
  } exp_t;

  exp_t exp_q[$];
  logic        e_carry = 1'b0;
  logic [31:0] e_ld = '0;

  branch_pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_result (alu_result),
    .alu_sign   (alu_sign),
    .alu_cout   (alu_cout),
    .flag_we    (flag_we),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_op      (br_op),
    .br_target  (br_target),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .pc         (pc),
    .taken      (taken),
    .flush      (flush),
    .link_we    (link_we),
    .link_data  (link_data),
    .carry      (carry)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc"}, pc, 32'h0);
    chk({tag, " carry"}, 32'(carry), 32'h0);
    chk({tag, " if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, " br_ready"}, 32'(br_ready), 32'h0);
    chk({tag, " taken"}, 32'(taken), 32'h0);
    chk({tag, " flush"}, 32'(flush), 32'h0);
    chk({tag, " link_we"}, 32'(link_we), 32'h0);
    chk({tag, " link_data"}, link_data, 32'h0);
`ifdef BRANCH_STATS_EN
    chk({tag, " stat_taken"}, 32'(stat_taken), 32'h0);
    chk({tag, " stat_not_taken"}, 32'(stat_not_taken), 32'h0);
`endif
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic bv, input logic [2:0] op, input logic [31:0] tgt,
                      input logic ir, input logic fwe, input logic co, input logic [1:0] sg,
                      input logic [31:0] epc, input logic etk, input logic elwe,
                      input logic ebr);
    exp_t e;
    br_valid  = bv;
    br_op     = op;
    br_target = tgt;
    if_ready  = ir;
    flag_we   = fwe;
    alu_cout  = co;
    alu_sign  = sg;
    e.pc  = epc;
    e.tk  = etk;
    e.lwe = elwe;
    e.ld  = e_ld;
    e.c   = e_carry;
    e.br  = ebr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic ir, input logic [31:0] epc, input logic ebr);
    step(1'b0, 3'b000, 32'h0, ir, 1'b0, 1'b0, 2'b00, epc, 1'b0, 1'b0, ebr);
  endtask

  task automatic quiet_inputs();
    br_valid = 1'b0;
    br_op    = 3'b000;
    flag_we  = 1'b0;
    alu_cout = 1'b0;
    alu_sign = 2'b00;
    if_ready = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("taken", 32'(taken), 32'(e.tk));
        chk("flush", 32'(flush), 32'(e.tk));
        chk("link_we", 32'(link_we), 32'(e.lwe));
        chk("link_data", link_data, e.ld);
        chk("carry", 32'(carry), 32'(e.c));
        chk("br_ready", 32'(br_ready), 32'(e.br));
        chk("if_valid", 32'(if_valid), 32'h1);
      end
    end
  end

  initial begin
    #13;
    chk_reset_vals("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle if_valid", 32'(if_valid), 32'h0);
    chk("idle br_ready", 32'(br_ready), 32'h0);

    idle(1'b1, 32'h0, 1'b1);
    idle(1'b1, 32'h4, 1'b1);
    idle(1'b1, 32'h8, 1'b1);
    idle(1'b1, 32'hC, 1'b1);
    idle(1'b1, 32'h10, 1'b1);
    idle(1'b0, 32'h10, 1'b0);
    idle(1'b0, 32'h10, 1'b0);
    idle(1'b0, 32'h10, 1'b0);
    idle(1'b1, 32'h14, 1'b1);
    e_carry = 1'b1;
    step(1'b0, 3'b000, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h18, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b110, 32'h100, 1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h104, 1'b1);
    step(1'b1, 3'b111, 32'h200, 1'b1, 1'b0, 1'b0, 2'b00, 32'h108, 1'b0, 1'b0, 1'b1);
    e_carry = 1'b0;
    step(1'b1, 3'b110, 32'h300, 1'b1, 1'b1, 1'b0, 2'b00, 32'h300, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b110, 32'h400, 1'b1, 1'b0, 1'b0, 2'b00, 32'h304, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b010, 32'h40, 1'b1, 1'b0, 1'b0, 2'b10, 32'h40, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 32'h40, 1'b0);
    idle(1'b1, 32'h44, 1'b1);
    step(1'b1, 3'b011, 32'h500, 1'b1, 1'b0, 1'b0, 2'b01, 32'h48, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b100, 32'h500, 1'b1, 1'b0, 1'b0, 2'b00, 32'h4C, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b011, 32'h503, 1'b1, 1'b0, 1'b0, 2'b00, 32'h500, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h504, 1'b1);
    step(1'b1, 3'b001, 32'h1C, 1'b1, 1'b0, 1'b0, 2'b00, 32'h1C, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h20, 1'b1);
    e_ld = 32'h24;
    step(1'b1, 3'b101, 32'h80, 1'b0, 1'b0, 1'b0, 2'b00, 32'h80, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 32'h84, 1'b1);
    step(1'b1, 3'b000, 32'h999, 1'b1, 1'b0, 1'b0, 2'b00, 32'h88, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b100, 32'h600, 1'b1, 1'b0, 1'b0, 2'b11, 32'h600, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h604, 1'b1);
    step(1'b1, 3'b010, 32'h700, 1'b1, 1'b0, 1'b0, 2'b11, 32'h608, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b001, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 2'b00, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'hFFFF_FFFC, 1'b1);
    idle(1'b1, 32'h0, 1'b1);
    step(1'b1, 3'b001, 32'h900, 1'b1, 1'b0, 1'b0, 2'b00, 32'h900, 1'b1, 1'b0, 1'b0);

    // Now in FLUSH: asynchronous reset must clear outputs without a clock edge.
    #3;
    quiet_inputs();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e_carry = 1'b0;
    e_ld = 32'h0;
    #1;
    chk("reidle if_valid", 32'(if_valid), 32'h0);

    idle(1'b1, 32'h0, 1'b1);
    step(1'b1, 3'b011, 32'h10, 1'b1, 1'b0, 1'b0, 2'b00, 32'h10, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h14, 1'b1);
    step(1'b1, 3'b100, 32'h20, 1'b1, 1'b0, 1'b0, 2'b01, 32'h20, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h24, 1'b1);
    step(1'b1, 3'b010, 32'h777, 1'b1, 1'b0, 1'b0, 2'b01, 32'h28, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b110, 32'h777, 1'b1, 1'b0, 1'b0, 2'b00, 32'h2C, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b111, 32'h30, 1'b1, 1'b0, 1'b0, 2'b00, 32'h30, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h34, 1'b1);
    step(1'b1, 3'b001, 32'h40, 1'b1, 1'b0, 1'b0, 2'b00, 32'h40, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 32'h44, 1'b1);
    quiet_inputs();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
`ifdef BRANCH_STATS_EN
    chk("stat_taken", 32'(stat_taken), 32'd3);
    chk("stat_not_taken", 32'(stat_not_taken), 32'd2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage sitting directly downstream of the ALU in the single-issue core. It holds the architectural carry flag (latched from ALU `cout`), evaluates branch conditions using the ALU `sign` output and the carry flag, and sequences the PC toward instruction memory with a valid/ready fetch handshake. It also produces the link write for `bl` and a one-cycle flush after every taken branch.

## Interface
- `PC_W`, 32: PC and data width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_result`  in  32  ALU result (reserved for flag debug; not used for conditions).
- `alu_sign`  in  2  ALU sign: 2'b00 zero, 2'b01 positive, 2'b10 negative, 2'b11 illegal (treated as positive).
- `alu_cout`  in  1  ALU carry out.
- `flag_we`  in  1  latch `alu_cout` into carry flag this cycle (arithmetic ops only).
- `br_valid`  in  1  branch request present.
- `br_ready`  out  1  branch request accepted this cycle.
- `br_op`  in  3  000 seq, 001 br, 010 bltz, 011 bz, 100 bnz, 101 bl, 110 bcy, 111 bncy.
- `br_target`  in  PC_W  absolute target address.
- `if_valid`  out  1  `pc` is a valid fetch address.
- `if_ready`  in  1  instruction memory accepts `pc`.
- `pc`  out  PC_W  current fetch address.
- `taken`  out  1  one-cycle pulse, branch taken.
- `flush`  out  1  kill instruction in fetch.
- `link_we`  out  1  write `link_data` to ra.
- `link_data`  out  PC_W  return address, PC+4 of the `bl`.
- `carry`  out  1  architectural carry flag.

## Operation
- States: RESET_IDLE, RUN, HOLD, FLUSH.
- RESET_IDLE: entered on reset; `if_valid`=0; unconditional move to RUN next cycle.
- RUN: `if_valid`=1, `br_ready`=1. On `if_ready`=1 and no accepted branch: `pc` <= `pc`+4. On `if_ready`=0: go HOLD, `pc` unchanged.
- HOLD: `if_valid`=1, `br_ready`=0, `pc` held; return to RUN when `if_ready`=1 (`pc`+4 on that edge).
- Branch accepted (`br_valid`&`br_ready`): conditions: br/bl always; bltz `sign`=10; bz `sign`=00; bnz `sign`!=00; bcy `carry`=1; bncy `carry`=0; seq never taken. Taken: `pc` <= `br_target` regardless of `if_ready`, `taken` pulses, go FLUSH. Not taken: behaves as plain RUN.
- bl: `link_we` pulses with `link_data`=`pc`+4 at acceptance edge, independent of fetch stall.
- FLUSH: `flush`=1, `if_valid`=1, `br_ready`=0, one cycle; then RUN (or HOLD if `if_ready`=0).
- Carry: updated on any cycle with `flag_we`=1, any state. Same-cycle `flag_we` and bcy/bncy: condition uses the old carry.
- PC arithmetic modulo 2^PC_W; `br_target` bits [1:0] forced to 0.

## Timing
- Reset values: `pc`=RESET_PC, `carry`=0, `if_valid`=0, `br_ready`=0, `taken`=0, `flush`=0, `link_we`=0, `link_data`=0, state RESET_IDLE.
- All outputs registered except `br_ready` and `if_valid` (Moore, decoded from state).
- Branch resolution latency: 1 cycle from acceptance to new `pc`; exactly one flushed slot.
- Reset mid-HOLD/FLUSH: immediate return to reset values; pending branch discarded.
- Wrap: `pc`=32'hFFFF_FFFC +4 -> 32'h0000_0000.

## Configuration
- `BRANCH_STATS_EN` defined: adds 16-bit saturating counters `stat_taken`, `stat_not_taken` (extra outputs), incremented on each accepted conditional branch (op 010,011,100,110,111), cleared on reset, saturate at 16'hFFFF.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Shared package `kgp_pkg`: `br_op` encodings, `alu_sign` encodings, state enum, `RESET_PC` default.
- Sub-module `branch_cond`: combinational condition evaluator (`br_op`, `alu_sign`, `carry` -> `cond_taken`).

## Test plan
- Reset release, `if_ready`=1: `pc` 0 -> 0 (RESET_IDLE) -> 4 -> 8; all outputs at reset values during reset.
- `flag_we`=1, `alu_cout`=1, then bcy target 32'h100: `taken` pulses, `pc`=32'h100, `flush`=1 for one cycle; bncy same state: not taken, `pc`+4.
- bltz with `alu_sign`=10, target 32'h40 -> taken; bz with `alu_sign`=01 -> not taken; bnz with `alu_sign`=00 -> not taken.
- bl at `pc`=32'h20, target 32'h80: `link_we`=1, `link_data`=32'h24, `pc`=32'h80.
- `if_ready`=0 for 3 cycles at `pc`=32'h10: HOLD, `pc` stays 32'h10, `br_ready`=0; then `pc`=32'h14.
- Async `rst_n` low during FLUSH: `pc`=RESET_PC, `flush`=0 immediately; with `BRANCH_STATS_EN`, 3 taken + 2 not-taken conditionals give counts 3/2.
